// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: stall arbitration, exception
// flush sequencing, stall watchdog and stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned MAX_STALL = 255,
  parameter int unsigned WD_W      = 8,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic              excp_eret,
  input  logic [31:0]       excp_base,
  input  logic [31:0]       epc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              new_pc_valid,
  output logic              stall_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MAX_STALL);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_STALL - 1);

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        stall_dec;
  logic [3:0]        win;
  logic [WD_W-1:0]   wd_cnt;

  // one-hot winner: a stage's request only counts if no later stage asks
  assign win[3] = stallreq_mem;
  assign win[2] = stallreq_ex & ~stallreq_mem;
  assign win[1] = stallreq_id & ~stallreq_ex & ~stallreq_mem;
  assign win[0] = stallreq_if & ~stallreq_id
                & ~stallreq_ex & ~stallreq_mem;

  always_comb begin
    stall_dec = 6'b000000;
    unique case (1'b1)
      win[3]:  stall_dec = 6'b011111;
      win[2]:  stall_dec = 6'b001111;
      win[1]:  stall_dec = 6'b000111;
      win[0]:  stall_dec = 6'b000011;
      default: stall_dec = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall        = 6'b000000;
    flush        = 1'b0;
    new_pc       = 32'h0;
    new_pc_valid = 1'b0;
    unique case (state)
      RUN: begin
        if (excp_valid) begin
          flush        = 1'b1;
          new_pc_valid = 1'b1;
          new_pc       = excp_eret ? epc : excp_base;
          state_nxt    = FLUSH;
        end else begin
          stall = stall_dec;
        end
      end
      FLUSH: begin
        // only bubbles in flight; fetch wait is the sole hold that matters
        stall     = stallreq_if ? 6'b000011 : 6'b000000;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (!stall[0]) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) stall_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall[0] && stall_cycles != {PERF_W{1'b1}})
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against
// a cycle-level reference model of stall/flush/watchdog/perf behaviour.
module tb_pipe_ctrl;

  localparam int MAXS = 4;
  localparam int PW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic          excp_valid, excp_eret;
  logic [31:0]   excp_base, epc;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          new_pc_valid;
  logic          stall_timeout;
  logic [PW-1:0] stall_cycles;

  pipe_ctrl #(
    .MAX_STALL(MAXS),
    .WD_W(3),
    .PERF_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_if(stallreq_if),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid),
    .excp_eret(excp_eret),
    .excp_base(excp_base),
    .epc(epc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .new_pc_valid(new_pc_valid),
    .stall_timeout(stall_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit in_flush;
  int run_len;
  int total;
  bit to_m;

  logic [5:0]  e_stall;
  logic        e_flush, e_npv;
  logic [31:0] e_npc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] decode(input logic [3:0] req);
    // request k (if=0..mem=3) holds stages 0..k+1
    for (int k = 3; k >= 0; k--)
      if (req[k]) return 6'((1 << (k + 2)) - 1);
    return 6'd0;
  endfunction

  function automatic void model_outs();
    logic [3:0] req;
    req = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
    e_flush = 1'b0;
    e_npv   = 1'b0;
    e_npc   = 32'h0;
    if (in_flush) begin
      e_stall = stallreq_if ? 6'b000011 : 6'b000000;
    end else if (excp_valid) begin
      e_stall = 6'b000000;
      e_flush = 1'b1;
      e_npv   = 1'b1;
      e_npc   = excp_eret ? epc : excp_base;
    end else begin
      e_stall = decode(req);
    end
  endfunction

  function automatic void model_reset();
    in_flush = 1'b0;
    run_len  = 0;
    total    = 0;
    to_m     = 1'b0;
  endfunction

  task automatic check_all(input string tag);
    int perf;
    model_outs();
    perf = (total > 255) ? 255 : total;
    chk({tag, ".stall"}, 64'(stall), 64'(e_stall));
    chk({tag, ".flush"}, 64'(flush), 64'(e_flush));
    chk({tag, ".new_pc"}, 64'(new_pc), 64'(e_npc));
    chk({tag, ".npv"}, 64'(new_pc_valid), 64'(e_npv));
    chk({tag, ".timeout"}, 64'(stall_timeout), 64'(to_m));
    chk({tag, ".cycles"}, 64'(stall_cycles), 64'(perf));
  endtask

  // apply inputs away from the edge, check, then clock once
  task automatic step(input string tag, input logic [3:0] req,
                      input logic ev, input logic er,
                      input logic [31:0] b, input logic [31:0] e);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excp_valid = ev;
    excp_eret  = er;
    excp_base  = b;
    epc        = e;
    #1;
    check_all(tag);
    @(posedge clk);
    if (e_stall[0]) begin
      run_len++;
      total++;
    end else begin
      run_len = 0;
    end
    if (run_len >= MAXS) to_m = 1'b1;
    in_flush = !in_flush && ev;
    @(negedge clk);
  endtask

  task automatic rst_pulse(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
    excp_valid = 1'b0;
    excp_eret  = 1'b0;
    excp_base  = 32'h0;
    epc        = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("reset", 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("id_hold", 4'b0010, 0, 0, 0, 0);
    step("id_release", 4'b0000, 0, 0, 0, 0);
    step("multi_req", 4'b1101, 0, 0, 0, 0);
    step("drop_mem", 4'b0101, 0, 0, 0, 0);
    step("excp_ex", 4'b0100, 1, 0, 32'h40, 32'h1234);
    step("flush_ex", 4'b0100, 0, 0, 32'h40, 32'h1234);
    step("run_ex", 4'b0100, 0, 0, 0, 0);
    step("eret", 4'b0000, 1, 1, 32'h80, 32'h00400010);
    step("excp_in_flush", 4'b0001, 1, 0, 32'h80, 32'h0);
    step("after_flush", 4'b0000, 0, 1, 32'h80, 32'h55);
    for (int i = 0; i < 6; i++)
      step("mem_hold", 4'b1000, 0, 0, 0, 0);
    step("mem_release", 4'b0000, 0, 0, 0, 0);
    step("mem_again", 4'b1000, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++)
      step("perf_sat", 4'b1000, 0, 0, 0, 0);
    step("excp_mid", 4'b1000, 1, 0, 32'h40, 0);
    rst_pulse("rst_mid_flush");
    step("post_rst", 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(3) == 0) r = 4'b0000;
      step("rand", r, ($urandom_range(7) == 0), 1'($urandom),
           $urandom, $urandom);
      if ($urandom_range(149) == 0) rst_pulse("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
